sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO for the JPEG encoder's entropy-coded data path, buffering encoded words between the Huffman packer and the FF byte-stuffing / output stage. Generalises the fixed 32×16 FIFO in data width, depth and read mode. It adds full and almost-full back-pressure, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode.

---
 rtl/sync_fifo_param.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO for entropy-coded words, parametrised in width, depth and read mode.
// Latency: registered mode gives data one cycle after an accepted read; FWFT mode shows the head word once the FIFO is non-empty.
// Backpressure: writes are dropped while full (overflow sticks), reads ignored while empty (underflow sticks); almost_full warns early.
module sync_fifo_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2,
    parameter bit FWFT     = 1'b0,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_req,
    output logic [DATA_W-1:0] read_data,
    output logic              rdata_valid,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = CW - 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic              wr_acc, rd_acc;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    // Status comes from the pointer registers only, so no input reaches these outputs combinationally.
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (count >= CW'(AFULL_TH));
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    // Flush wins over any access in the same cycle; a full FIFO never passes a write through a read.
    assign wr_acc = write_enable && !fifo_full && !flush;
    assign rd_acc = read_req && !fifo_empty && !flush;

    // Next pointers and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
            if (write_enable && fifo_full) ovf_d = 1'b1;
            if (read_req && fifo_empty)    unf_d = 1'b1;
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_addr] <= write_data;
    end

    generate
        if (FWFT) begin : g_fwft
            logic [DATA_W-1:0] head_q, head_d;
            logic [AW-1:0]     rd_addr_nxt;

            assign rd_addr_nxt = rd_addr + AW'(1);

            // The head register mirrors the oldest word; it is refilled from the array on a pop,
            // or straight from write_data when the incoming word becomes the new head.
            always_comb begin
                head_d = head_q;
                if (rd_acc) begin
                    if (count > CW'(1))  head_d = mem_q[rd_addr_nxt];
                    else if (wr_acc)     head_d = write_data;
                end else if (fifo_empty && wr_acc) begin
                    head_d = write_data;
                end
            end

            // Head word register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) head_q <= '0;
                else        head_q <= head_d;
            end

            assign read_data   = head_q;
            assign rdata_valid = !fifo_empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rdata_q, rdata_d;
            logic              rvld_q, rvld_d;

            // An accepted read captures the head; the valid pulse lasts exactly one cycle.
            always_comb begin
                rdata_d = rdata_q;
                rvld_d  = 1'b0;
                if (rd_acc) begin
                    rdata_d = mem_q[rd_addr];
                    rvld_d  = 1'b1;
                end
            end

            // Read output registers; flush clears only the valid bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    rvld_q  <= 1'b0;
                end else begin
                    rdata_q <= rdata_d;
                    rvld_q  <= rvld_d;
                end
            end

            assign read_data   = rdata_q;
            assign rdata_valid = rvld_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered-read and FWFT instances share one stimulus stream.
// Expected values come from a queue model updated at every clock edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_sync_fifo_param;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int AF = DP - 2;
    localparam int CW = $clog2(DP) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          we;
    logic [DW-1:0] wd;
    logic          rr;

    logic [DW-1:0] rd0, rd1;
    logic          vld0, vld1, emp0, emp1, ful0, ful1, af0, af1, ovf0, ovf1, unf0, unf1;
    logic [CW-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .FWFT(1'b0)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .write_enable(we), .write_data(wd),
        .read_req(rr), .read_data(rd0), .rdata_valid(vld0), .fifo_empty(emp0),
        .fifo_full(ful0), .almost_full(af0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .write_enable(we), .write_data(wd),
        .read_req(rr), .read_data(rd1), .rdata_valid(vld1), .fifo_empty(emp1),
        .fifo_full(ful1), .almost_full(af1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    // Reference model
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_vld0;
    logic [DW-1:0] m_rd0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_vld0 = 1'b0;
        m_rd0  = '0;
    endtask

    // Apply the FIFO rules to the model for the inputs present at this edge.
    task automatic model_edge(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        int n;
        n = q.size();
        if (f) begin
            q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_vld0 = 1'b0;
        end else begin
            if (w && n == DP) m_ovf = 1'b1;
            if (r && n == 0)  m_unf = 1'b1;
            m_vld0 = 1'b0;
            if (r && n > 0) begin
                m_rd0  = q.pop_front();
                m_vld0 = 1'b1;
            end
            if (w && n < DP) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count0", cnt0, n);
        chk("count1", cnt1, n);
        chk("empty0", emp0, n == 0);
        chk("empty1", emp1, n == 0);
        chk("full0", ful0, n == DP);
        chk("full1", ful1, n == DP);
        chk("afull0", af0, n >= AF);
        chk("afull1", af1, n >= AF);
        chk("ovf0", ovf0, m_ovf);
        chk("ovf1", ovf1, m_ovf);
        chk("unf0", unf0, m_unf);
        chk("unf1", unf1, m_unf);
        chk("vld0", vld0, m_vld0);
        chk("rdata0", rd0, m_rd0);
        chk("vld1", vld1, n != 0);
        if (n != 0) chk("rdata1", rd1, q[0]);
    endtask

    // One clock cycle: drive, clock, update model, sample.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        we    = w;
        wd    = d;
        rr    = r;
        flush = f;
        @(posedge clk);
        if (rst_n) model_edge(w, d, r, f);
        else       model_reset();
        #1;
        check_all();
    endtask

    task automatic fill_to(input int n);
        while (q.size() < n) cyc(1'b1, $urandom, 1'b0, 1'b0);
    endtask

    task automatic drain_to(input int n);
        while (q.size() > n) cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    int  nw;
    bit  w, r, f;
    bit  full_seen;

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        we    = 1'b0;
        wd    = '0;
        rr    = 1'b0;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #2 check_all();
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1234, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Fill with 0..15, then one write into a full FIFO
        for (int i = 0; i < DP; i++) cyc(1'b1, i, 1'b0, 1'b0);
        chk("fill_full", ful0, 1'b1);
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("fill_ovf", ovf0, 1'b1);
        chk("fill_cnt", cnt0, DP);

        // Drain back-to-back, then one read of an empty FIFO
        for (int i = 0; i < DP; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("drain_data", rd0, i);
            chk("drain_vld", vld0, 1'b1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_unf", unf0, 1'b1);
        chk("drain_vld_off", vld0, 1'b0);
        chk("drain_cnt", cnt0, 0);

        // Wrap-around with occupancy held in 3..5
        cyc(1'b0, '0, 1'b0, 1'b1);
        fill_to(4);
        nw = 4;
        full_seen = 1'b0;
        while (nw < 40) begin
            if (q.size() <= 3)      begin w = 1'b1; r = 1'($urandom_range(0, 1)); end
            else if (q.size() >= 5) begin r = 1'b1; w = 1'($urandom_range(0, 1)); end
            else                    begin w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
            cyc(w, $urandom, r, 1'b0);
            if (w) nw++;
            if (ful0) full_seen = 1'b1;
        end
        chk("wrap_no_full", full_seen, 1'b0);
        drain_to(0);

        // Simultaneous read and write at full, empty and mid occupancy
        fill_to(DP);
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        chk("sim_full_cnt", cnt0, DP - 1);
        chk("sim_full_ovf", ovf0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 32'h66, 1'b1, 1'b0);
        chk("sim_empty_cnt", cnt0, 1);
        chk("sim_empty_unf", unf0, 1'b1);
        fill_to(8);
        cyc(1'b1, 32'h77, 1'b1, 1'b0);
        chk("sim_mid_cnt", cnt0, 8);

        // First-word-fall-through behaviour
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        chk("fwft_a5", rd1, 32'hA5A5A5A5);
        chk("fwft_vld", vld1, 1'b1);
        cyc(1'b1, 32'h11, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0);
        chk("fwft_head0", rd1, 32'hA5A5A5A5);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_head1", rd1, 32'h11);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_head2", rd1, 32'h22);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_empty", emp1, 1'b1);
        chk("fwft_vld_off", vld1, 1'b0);

        // Flush mid-operation at count 9 with overflow set and a write pending
        fill_to(DP);
        cyc(1'b1, 32'hBAD, 1'b0, 1'b0);
        drain_to(9);
        chk("flush_pre_ovf", ovf0, 1'b1);
        cyc(1'b1, 32'hCAFE, 1'b0, 1'b1);
        chk("flush_cnt", cnt0, 0);
        chk("flush_ovf", ovf0, 1'b0);

        // Random traffic: write-heavy, then read-heavy, with rare flushes
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            f = ($urandom_range(0, 59) == 0);
            cyc(w, $urandom, r, f);
        end

        // Asynchronous reset in the middle of a cycle
        cyc(1'b0, '0, 1'b0, 1'b1);
        fill_to(5);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_cnt", cnt0, 0);
        chk("arst_rd0", rd0, 0);
        cyc(1'b1, 32'h99, 1'b1, 1'b0);
        #2 rst_n = 1'b1;
        cyc(1'b1, 32'h3C3C3C3C, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("arst_recover", rd0, 32'h3C3C3C3C);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
